// File: rtl/sdr_gfx_arbiter.sv
// sdr_gfx_arbiter
//   Three-port round-robin arbiter that funnels graphics ROM word reads
//   (BACK1, BACK2, FRONT) onto a single SDRAM controller request channel.
//   Each port has a one-deep pending slot. The most recent address wins
//   until the port is issued. Completion data is returned per port, with a
//   one-cycle rdy strobe.
//
// Optional feature: define SDR_ARB_WATCHDOG_EN to enable a WAIT watchdog.
//   If TIMEOUT_CYCLES cycles pass without sdr_rdy, the access is aborted:
//   tmo_o and rdy_o[g] pulse, and dataG_o is left untouched.
//   When SDR_ARB_WATCHDOG_EN is undefined, tmo_o is tied to 0.
//
// Ports
//   clk_ram             single clock, rising edge
//   RESETn              asynchronous active-low reset
//   req_i[2:0]          one-cycle request strobes (0=BACK1, 1=BACK2, 2=FRONT)
//   addr0_i..addr2_i    25-bit word address, sampled with req_i[n]
//   rdy_o[2:0]          one-cycle data-valid strobe per port
//   data0_o..data2_o    returned word, held until the next rdy_o[n]
//   sdr_addr            address to the SDRAM controller, held between issues
//   sdr_req             one-cycle request strobe to the SDRAM controller
//   sdr_rdy             one-cycle completion strobe from the controller
//   sdr_data            read data, valid with sdr_rdy
//   tmo_o               one-cycle watchdog-abort strobe
module sdr_gfx_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk_ram,
  input  logic        RESETn,
  input  logic [2:0]  req_i,
  input  logic [24:0] addr0_i,
  input  logic [24:0] addr1_i,
  input  logic [24:0] addr2_i,
  output logic [2:0]  rdy_o,
  output logic [15:0] data0_o,
  output logic [15:0] data1_o,
  output logic [15:0] data2_o,
  output logic [24:0] sdr_addr,
  output logic        sdr_req,
  input  logic        sdr_rdy,
  input  logic [15:0] sdr_data,
  output logic        tmo_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  pend, pend_nxt;
  logic [24:0] addr_q [3];
  logic [1:0]  gnt;
  logic [1:0]  last_grant;
  logic        vld_p1;
  logic [15:0] data_p1;
  logic        wd_fire;

  // Round-robin search starting one past the last served port.
  function automatic logic [1:0] rr_pick(input logic [1:0] last,
                                         input logic [2:0] p);
    logic [1:0] c0, c1, c2;
    case (last)
      2'd0:    begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; end
      2'd1:    begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
      default: begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; end
    endcase
    if (p[c0])      return c0;
    else if (p[c1]) return c1;
    else            return c2;
  endfunction

  // A request in the grantee's ISSUE cycle re-arms its slot, so the clear
  // is applied before the new strobes are merged in.
  always_comb begin
    pend_nxt = pend;
    if (state == S_ISSUE) pend_nxt[gnt] = 1'b0;
    pend_nxt = pend_nxt | req_i;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (|pend) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (sdr_rdy || wd_fire) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef SDR_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  assign wd_fire = (state == S_WAIT) && !sdr_rdy &&
                   (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  // Counts WAIT cycles; cleared on every cycle that does not stay in WAIT.
  always_ff @(posedge clk_ram or negedge RESETn) begin
    if (!RESETn) begin
      wd_cnt <= '0;
      tmo_o  <= 1'b0;
    end else begin
      tmo_o <= wd_fire;
      if (state == S_WAIT && state_nxt == S_WAIT) wd_cnt <= wd_cnt + 1'b1;
      else                                        wd_cnt <= '0;
    end
  end
`else
  assign wd_fire = 1'b0;
  assign tmo_o   = 1'b0;
`endif

  // Request capture: addresses are plain data, no reset needed.
  always_ff @(posedge clk_ram) begin
    if (req_i[0]) addr_q[0] <= addr0_i;
    if (req_i[1]) addr_q[1] <= addr1_i;
    if (req_i[2]) addr_q[2] <= addr2_i;
    // p1: completion data staged one cycle ahead of rdy_o
    if (state == S_WAIT && sdr_rdy) data_p1 <= sdr_data;
  end

  always_ff @(posedge clk_ram or negedge RESETn) begin
    if (!RESETn) begin
      state      <= S_IDLE;
      pend       <= 3'b000;
      last_grant <= 2'd2;
      gnt        <= 2'd0;
      sdr_req    <= 1'b0;
      sdr_addr   <= '0;
      rdy_o      <= 3'b000;
      vld_p1     <= 1'b0;
      data0_o    <= 16'h0000;
      data1_o    <= 16'h0000;
      data2_o    <= 16'h0000;
    end else begin
      state   <= state_nxt;
      pend    <= pend_nxt;
      sdr_req <= 1'b0;
      rdy_o   <= 3'b000;
      vld_p1  <= 1'b0;

      if (state == S_IDLE && |pend) gnt <= rr_pick(last_grant, pend);

      if (state == S_ISSUE) begin
        sdr_req  <= 1'b1;
        sdr_addr <= addr_q[gnt];
      end

      // p0: completion accepted only while waiting
      if (state == S_WAIT && sdr_rdy) begin
        vld_p1     <= 1'b1;
        last_grant <= gnt;
      end

      // p1: deliver the staged word to the grantee
      if (vld_p1) begin
        rdy_o[gnt] <= 1'b1;
        case (gnt)
          2'd0:    data0_o <= data_p1;
          2'd1:    data1_o <= data_p1;
          default: data2_o <= data_p1;
        endcase
      end

      // Abort: strobe rdy without touching the port's data register.
      if (wd_fire) begin
        rdy_o[gnt] <= 1'b1;
        last_grant <= gnt;
      end
    end
  end

endmodule

// File: tb/tb_sdr_gfx_arbiter.sv
module tb_sdr_gfx_arbiter;

  localparam int TMO = 64;

  logic        clk_ram = 1'b0;
  logic        RESETn  = 1'b0;
  logic [2:0]  req_i   = 3'b000;
  logic [24:0] addr0_i = '0, addr1_i = '0, addr2_i = '0;
  logic [2:0]  rdy_o;
  logic [15:0] data0_o, data1_o, data2_o;
  logic [24:0] sdr_addr;
  logic        sdr_req;
  logic        sdr_rdy  = 1'b0;
  logic [15:0] sdr_data = '0;
  logic        tmo_o;

  sdr_gfx_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_ram (clk_ram), .RESETn (RESETn), .req_i (req_i),
    .addr0_i (addr0_i), .addr1_i (addr1_i), .addr2_i (addr2_i),
    .rdy_o (rdy_o), .data0_o (data0_o), .data1_o (data1_o), .data2_o (data2_o),
    .sdr_addr (sdr_addr), .sdr_req (sdr_req), .sdr_rdy (sdr_rdy),
    .sdr_data (sdr_data), .tmo_o (tmo_o)
  );

  always #5 clk_ram = ~clk_ram;

  int n_checks = 0;
  int n_errors = 0;
  int cycle    = 0;

  // Transaction-level reference: pending slots, current access phase
  // (0 idle, 1 granted, 2 outstanding), and the expected pin values.
  int          m_phase, m_g, m_last, m_wait, m_out_port;
  logic [2:0]  m_pend;
  logic [24:0] m_addr [3];
  logic        m_out_valid;
  logic [15:0] m_out_data;
  logic [2:0]  exp_rdy;
  logic        exp_req, exp_tmo;
  logic [24:0] exp_addr;
  logic [15:0] exp_data [3];

  // SDRAM controller emulation
  int   mem_cnt  = 0;
  int   lat_cfg  = 0;      // 0 = random latency 1..6
  logic stray_en = 1'b0;
  logic withhold = 1'b0;
  logic [15:0] data_cfg = '0;
  logic        data_fix = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cycle, obs, exp);
    end
  endtask

  function automatic int rr(input int last, input logic [2:0] p);
    for (int i = 1; i <= 3; i++)
      if (p[(last + i) % 3]) return (last + i) % 3;
    return last;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_g = 0; m_last = 2; m_wait = 0; m_pend = 3'b000;
    m_out_valid = 1'b0; m_out_port = 0; m_out_data = '0;
    exp_rdy = 3'b000; exp_req = 1'b0; exp_tmo = 1'b0; exp_addr = '0;
    for (int p = 0; p < 3; p++) begin exp_data[p] = '0; m_addr[p] = '0; end
  endtask

  task automatic model_edge(input logic [2:0] req, input logic [24:0] a0,
                            input logic [24:0] a1, input logic [24:0] a2,
                            input logic rdy, input logic [15:0] d);
    exp_rdy = 3'b000; exp_req = 1'b0; exp_tmo = 1'b0;
    if (m_out_valid) begin
      exp_rdy[m_out_port] = 1'b1;
      exp_data[m_out_port] = m_out_data;
      m_out_valid = 1'b0;
    end
    case (m_phase)
      0: if (m_pend != 3'b000) begin m_g = rr(m_last, m_pend); m_phase = 1; end
      1: begin
        exp_req = 1'b1; exp_addr = m_addr[m_g];
        m_pend[m_g] = 1'b0; m_phase = 2; m_wait = 0;
      end
      default: begin
        if (rdy) begin
          m_out_valid = 1'b1; m_out_port = m_g; m_out_data = d;
          m_last = m_g; m_phase = 0;
        end
`ifdef SDR_ARB_WATCHDOG_EN
        else begin
          m_wait++;
          if (m_wait == TMO) begin
            exp_rdy[m_g] = 1'b1; exp_tmo = 1'b1; m_last = m_g; m_phase = 0;
          end
        end
`endif
      end
    endcase
    if (req[0]) begin m_pend[0] = 1'b1; m_addr[0] = a0; end
    if (req[1]) begin m_pend[1] = 1'b1; m_addr[1] = a1; end
    if (req[2]) begin m_pend[2] = 1'b1; m_addr[2] = a2; end
  endtask

  task automatic check_pins();
    chk("sdr_req",  {31'b0, sdr_req}, {31'b0, exp_req});
    chk("sdr_addr", {7'b0, sdr_addr}, {7'b0, exp_addr});
    chk("rdy_o",    {29'b0, rdy_o},   {29'b0, exp_rdy});
    chk("data0",    {16'b0, data0_o}, {16'b0, exp_data[0]});
    chk("data1",    {16'b0, data1_o}, {16'b0, exp_data[1]});
    chk("data2",    {16'b0, data2_o}, {16'b0, exp_data[2]});
    chk("tmo_o",    {31'b0, tmo_o},   {31'b0, exp_tmo});
  endtask

  // One clock: drive inputs at negedge, advance the model, check at next negedge.
  task automatic step(input logic [2:0] req, input logic [24:0] a0,
                      input logic [24:0] a1, input logic [24:0] a2);
    logic        rdy_in;
    logic [15:0] d_in;
    rdy_in = 1'b0;
    d_in   = data_fix ? data_cfg : 16'($urandom);
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) rdy_in = 1'b1;
    end else if (stray_en && m_phase != 2 && $urandom_range(0, 7) == 0) begin
      rdy_in = 1'b1;
    end
    req_i = req; addr0_i = a0; addr1_i = a1; addr2_i = a2;
    sdr_rdy  = rdy_in;
    sdr_data = rdy_in ? d_in : 16'($urandom);
    model_edge(req, a0, a1, a2, rdy_in, d_in);
    @(posedge clk_ram);
    @(negedge clk_ram);
    cycle++;
    check_pins();
    if (sdr_req === 1'b1 && !withhold)
      mem_cnt = (lat_cfg == 0) ? $urandom_range(1, 6) : lat_cfg;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(3'b000, 25'($urandom), 25'($urandom), 25'($urandom));
  endtask

  task automatic apply_reset();
    req_i = 3'b000; sdr_rdy = 1'b0;
    RESETn = 1'b0;
    #1;
    model_reset();
    check_pins();
    @(posedge clk_ram);
    @(negedge clk_ram);
    RESETn = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk_ram);
    apply_reset();

    // Single request, controller answers 5 cycles after sdr_req.
    lat_cfg = 5; data_fix = 1'b1; data_cfg = 16'hA55A;
    step(3'b001, 25'h0040010, 25'h0, 25'h0);
    idle(10);
    chk("single_data0", {16'b0, data0_o}, 32'h0000A55A);
    data_fix = 1'b0;

    // Simultaneous requests, then a two-port burst.
    lat_cfg = 2;
    step(3'b111, 25'h11, 25'h22, 25'h33);
    idle(18);
    step(3'b011, 25'h44, 25'h55, 25'h0);
    idle(12);

    // Overwrite while port 0 is outstanding.
    lat_cfg = 6;
    step(3'b001, 25'h1000, 25'h0, 25'h0);
    idle(3);
    step(3'b010, 25'h0, 25'h100, 25'h0);
    step(3'b010, 25'h0, 25'h200, 25'h0);
    idle(20);

    // Port 2 re-requests in its own ISSUE cycle.
    lat_cfg = 3;
    step(3'b100, 25'h0, 25'h0, 25'h1ABCDEF);
    idle(1);
    step(3'b100, 25'h0, 25'h0, 25'h0FEDCBA);
    idle(16);

    // Reset while outstanding; the late completion must be ignored.
    lat_cfg = 6;
    step(3'b001, 25'h777, 25'h0, 25'h0);
    idle(4);
    apply_reset();
    idle(8);

`ifdef SDR_ARB_WATCHDOG_EN
    withhold = 1'b1;
    step(3'b001, 25'h5000, 25'h0, 25'h0);
    step(3'b010, 25'h0, 25'h6000, 25'h0);
    idle(TMO + 6);
    withhold = 1'b0;
    idle(15);
`endif

    // Randomised traffic with stray completions outside WAIT.
    lat_cfg = 0; stray_en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      logic [2:0] r;
      r[0] = ($urandom_range(0, 3) == 0);
      r[1] = ($urandom_range(0, 3) == 0);
      r[2] = ($urandom_range(0, 3) == 0);
      step(r, 25'($urandom), 25'($urandom), 25'($urandom));
    end
    stray_en = 1'b0;
    idle(20);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
